array_fifo_ctrl: RTL and testbench

ARRAY_FIFO_CTRL -- requirements
Module: array_fifo_ctrl

---
 rtl/array_pkg.sv | 19 +
 rtl/array_structural.sv | 25 ++
 rtl/array_fifo_ctrl.sv | 78 +++++++
 tb/tb_array_fifo_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/array_pkg.sv
// array_pkg: shared FIFO constants and occupancy-state encoding.
package array_pkg;

    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_PTR_W = 2;
    localparam int FIFO_CNT_W = 3;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_t;

    function automatic occ_t occ_of(input logic [FIFO_CNT_W-1:0] cnt);
        return (cnt == '0) ? OCC_EMPTY :
               (cnt == FIFO_CNT_W'(FIFO_DEPTH)) ? OCC_FULL : OCC_PARTIAL;
    endfunction

endpackage

// File: rtl/array_structural.sv
// array_structural: 4-word register-file storage, synchronous write, combinational read.
import array_pkg::*;

module array_structural #(
    parameter int WIDTH = 8,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  write_en,
    input  logic [FIFO_PTR_W-1:0] write_addr,
    input  logic [WIDTH-1:0]      write_data,
    input  logic [FIFO_PTR_W-1:0] read_addr,
    output logic [WIDTH-1:0]      read_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (write_en)
            mem_q[write_addr] <= write_data;
    end

    assign read_data = mem_q[read_addr];

endmodule

// File: rtl/array_fifo_ctrl.sv
// array_fifo_ctrl: 4-entry show-ahead FIFO controller over array_structural.
// Optional ARRAY_FIFO_PEAK_EN adds a peak-occupancy output.
import array_pkg::*;

module array_fifo_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [FIFO_CNT_W-1:0] count,
    output logic                  full,
`ifdef ARRAY_FIFO_PEAK_EN
    output logic                  empty,
    output logic [FIFO_CNT_W-1:0] peak
`else
    output logic                  empty
`endif
);

    logic [FIFO_PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_CNT_W-1:0] count_q, count_d;
    occ_t                  state_q, state_d;
    logic                  push, pop;

    // Handshakes are gated by rst so a push coincident with reset is dropped.
    assign full      = !rst && state_q == OCC_FULL;
    assign empty     = rst || state_q == OCC_EMPTY;
    assign in_ready  = !full && !rst;
    assign out_valid = !empty && !rst;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = rst ? '0 : count_q;

    always_comb begin
        wr_ptr_d = rst ? '0 : wr_ptr_q + FIFO_PTR_W'(push);
        rd_ptr_d = rst ? '0 : rd_ptr_q + FIFO_PTR_W'(pop);
        count_d  = rst ? '0 : count_q + FIFO_CNT_W'(push) - FIFO_CNT_W'(pop);
        state_d  = occ_of(count_d);
    end

    always_ff @(posedge clk) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
        state_q  <= state_d;
    end

`ifdef ARRAY_FIFO_PEAK_EN
    logic [FIFO_CNT_W-1:0] peak_q, peak_d;

    always_comb begin
        peak_d = rst ? '0 : (count_d > peak_q) ? count_d : peak_q;
    end

    always_ff @(posedge clk) begin
        peak_q <= peak_d;
    end

    assign peak = peak_q;
`endif

    array_structural #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk       (clk),
        .write_en  (push),
        .write_addr(wr_ptr_q),
        .write_data(in_data),
        .read_addr (rd_ptr_q),
        .read_data (out_data)
    );

endmodule

// File: tb/tb_array_fifo_ctrl.sv
// tb_array_fifo_ctrl: directed self-checking bench for array_fifo_ctrl.
// Peak checks are compiled only when ARRAY_FIFO_PEAK_EN is defined.
module tb_array_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [2:0] count;
    logic       full;
    logic       empty;
`ifdef ARRAY_FIFO_PEAK_EN
    logic [2:0] peak;
`endif
    int total = 0;
    int bad = 0;

    array_fifo_ctrl #(.WIDTH(8), .DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .count    (count),
        .full     (full),
`ifdef ARRAY_FIFO_PEAK_EN
        .empty    (empty),
        .peak     (peak)
`else
        .empty    (empty)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop_expect(input string name, input logic [7:0] exp);
        total++;
        if (out_valid !== 1'b1 || out_data !== exp) begin
            bad++;
            $display("FAIL %s: out_valid=%b out_data=%h, required 1/%h", name, out_valid, out_data, exp);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if ({in_ready, out_valid, count, full, empty} !== 7'b0_0_000_0_1) begin
            bad++;
            $display("FAIL reset_hold: ir=%b ov=%b cnt=%0d full=%b empty=%b, required 0 0 0 0 1",
                     in_ready, out_valid, count, full, empty);
        end
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release: in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic test_fill_drain();
        logic [7:0] v [4] = '{8'h00, 8'h33, 8'h66, 8'h99};
        for (int i = 0; i < 4; i++) push_word(v[i]);
        total++;
        if (full !== 1'b1 || in_ready !== 1'b0 || count !== 3'd4) begin
            bad++;
            $display("FAIL fill: full=%b in_ready=%b count=%0d, required 1 0 4", full, in_ready, count);
        end
        for (int i = 0; i < 4; i++) pop_expect("drain", v[i]);
        total++;
        if (empty !== 1'b1 || count !== 3'd0) begin
            bad++;
            $display("FAIL drain_empty: empty=%b count=%0d, required 1 0", empty, count);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] v [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
        for (int i = 0; i < 4; i++) push_word(v[i]);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (count !== 3'd4) begin
                bad++;
                $display("FAIL overflow_count: count=%0d, required 4", count);
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) pop_expect("overflow_order", v[i]);
        total++;
        if (empty !== 1'b1) begin
            bad++;
            $display("FAIL overflow_empty: empty=%b, required 1", empty);
        end
    endtask

    task automatic test_simultaneous();
        push_word(8'hA0);
        push_word(8'hA1);
        for (int i = 0; i < 6; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== 8'(8'hA0 + i)) begin
                bad++;
                $display("FAIL simul_data: out_data=%h, required %h", out_data, 8'(8'hA0 + i));
            end
            in_valid  = 1'b1;
            in_data   = 8'(8'hA2 + i);
            out_ready = 1'b1;
            tick();
            total++;
            if (count !== 3'd2) begin
                bad++;
                $display("FAIL simul_count: count=%0d, required 2", count);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        pop_expect("simul_tail", 8'hA6);
        pop_expect("simul_tail", 8'hA7);
    endtask

    task automatic test_latency();
        push_word(8'h5A);
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'h5A || count !== 3'd1) begin
            bad++;
            $display("FAIL latency: ov=%b data=%h count=%0d, required 1 5a 1", out_valid, out_data, count);
        end
        pop_expect("latency_pop", 8'h5A);
    endtask

    task automatic test_reset_mid();
        push_word(8'hC1);
        push_word(8'hC2);
        push_word(8'hC3);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        total++;
        if (count !== 3'd0 || empty !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: count=%0d empty=%b ov=%b, required 0 1 0", count, empty, out_valid);
        end
        push_word(8'h11);
        pop_expect("reset_mid_first", 8'h11);
        total++;
        if (empty !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_empty: empty=%b, required 1", empty);
        end
    endtask

`ifdef ARRAY_FIFO_PEAK_EN
    task automatic test_peak();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        push_word(8'h01);
        push_word(8'h02);
        push_word(8'h03);
        pop_expect("peak_pop", 8'h01);
        pop_expect("peak_pop", 8'h02);
        pop_expect("peak_pop", 8'h03);
        push_word(8'h04);
        total++;
        if (peak !== 3'd3) begin
            bad++;
            $display("FAIL peak: peak=%0d, required 3", peak);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (peak !== 3'd0) begin
            bad++;
            $display("FAIL peak_reset: peak=%0d, required 0", peak);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_simultaneous();
        test_latency();
        test_reset_mid();
`ifdef ARRAY_FIFO_PEAK_EN
        test_peak();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
